// File: rtl/i2s_tx_if.sv
// Purpose: sample handshake bundle between the filter chain and the I2S serialiser.
// Latency: none, wires only.
// Backpressure: sample_ready from the serialiser gates acceptance of left_in/right_in.
interface i2s_tx_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] left_in;
  logic [DATA_W-1:0] right_in;
  logic              sample_valid;
  logic              sample_ready;

  // Producer side: drives the stereo pair and its valid flag.
  modport master (
    output left_in,
    output right_in,
    output sample_valid,
    input  sample_ready
  );

  // Serialiser side: consumes the pair and reports buffer space.
  modport slave (
    input  left_in,
    input  right_in,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/i2s_tx.sv
// Purpose: stereo PCM to I2S serialiser; bus master generating BCLK/LRCLK from clk.
// Latency: a pair accepted before a frame load drives its left MSB 2*CLK_DIV clks after that load.
// Backpressure: one-pair holding buffer; sample_ready low while full, frame muted (underrun) if empty at load.
// Option: define I2S_TX_HOLD_LAST_EN to replay the last transferred pair on underrun instead of zeros.
module i2s_tx #(
  parameter int DATA_W  = 16,
  parameter int SLOT_W  = 32,
  parameter int CLK_DIV = 4
) (
  input  logic    clk,
  input  logic    reset_n,
  i2s_tx_if.slave s_if,
  output logic    bclk,
  output logic    lrclk,
  output logic    sdata,
  output logic    frame_start,
  output logic    underrun
);

  localparam int FRAME_W = 2 * SLOT_W;
  localparam int BC_W    = $clog2(FRAME_W);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [BC_W-1:0]  BIT_LAST  = BC_W'(FRAME_W - 1);
  localparam logic [BC_W-1:0]  SLOT_LEN  = BC_W'(SLOT_W);
  localparam logic [BC_W-1:0]  DATA_LEN  = BC_W'(DATA_W);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);

  typedef struct packed {
    logic [DATA_W-1:0] left;
    logic [DATA_W-1:0] right;
  } pair_t;

  // Divider and bit position state
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             bclk_q, bclk_d;
  logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;

  // Sample storage
  pair_t            hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  pair_t            frame_q, frame_d;
  pair_t            mute_pair;

  // Registered outputs
  logic             lrclk_q, lrclk_d;
  logic             sdata_q, sdata_d;
  logic             frame_start_q, frame_start_d;
  logic             underrun_q, underrun_d;

  // Combinational helpers
  logic             div_tc;
  logic             fall_evt;
  logic [BC_W-1:0]  bit_nxt;
  logic             frame_load;
  logic             slot_nxt;
  logic [BC_W-1:0]  pos_nxt;
  logic             capture;
  logic [DATA_W-1:0] word;
  logic [BC_W-1:0]  bit_idx;
  logic             in_data;
  logic             word_bit;

  // BCLK divider: toggle bclk at terminal count; a fall event is the high->low toggle.
  always_comb begin
    div_tc    = (div_cnt_q == DIV_LAST);
    div_cnt_d = div_tc ? '0 : div_cnt_q + DIV_W'(1);
    bclk_d    = div_tc ? ~bclk_q : bclk_q;
    fall_evt  = div_tc & bclk_q;
  end

  // Bit position within the frame advances once per fall event; wrap to 0 loads a new frame.
  always_comb begin
    bit_nxt    = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BC_W'(1);
    bit_cnt_d  = fall_evt ? bit_nxt : bit_cnt_q;
    frame_load = fall_evt && (bit_nxt == '0);
    slot_nxt   = (bit_nxt >= SLOT_LEN);
    pos_nxt    = slot_nxt ? (bit_nxt - SLOT_LEN) : bit_nxt;
  end

  // Holding buffer: accept only when empty; a load that sees it full drains it.
  // A capture in the same cycle as a load from an empty buffer waits for the next frame.
  always_comb begin
    capture     = s_if.sample_valid && !hold_full_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (frame_load && hold_full_q) begin
      hold_full_d = 1'b0;
    end
    if (capture) begin
      hold_d.left  = s_if.left_in;
      hold_d.right = s_if.right_in;
      hold_full_d  = 1'b1;
    end
  end

`ifdef I2S_TX_HOLD_LAST_EN
  pair_t last_q, last_d;

  // Remember the most recent pair that actually reached the shift frame.
  always_comb begin
    last_d = last_q;
    if (frame_load && hold_full_q) begin
      last_d = hold_q;
    end
  end

  // Last-pair register, zero after reset so an early underrun still mutes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= '0;
    end else begin
      last_q <= last_d;
    end
  end

  assign mute_pair = last_q;
`else
  assign mute_pair = '0;
`endif

  // Shift frame: reload at frame boundary from holding, or the underrun fill pair.
  always_comb begin
    frame_d = frame_q;
    if (frame_load) begin
      frame_d = hold_full_q ? hold_q : mute_pair;
    end
  end

  // Serial data and word select, both moved only on BCLK falling edges.
  // Data occupies positions 1..DATA_W of each slot, MSB first, one BCLK after the lrclk edge.
  always_comb begin
    word          = slot_nxt ? frame_d.right : frame_d.left;
    bit_idx       = DATA_LEN - pos_nxt;
    in_data       = (pos_nxt != '0) && (pos_nxt <= DATA_LEN);
    word_bit      = |(word & (DATA_W'(1) << bit_idx));
    lrclk_d       = lrclk_q;
    sdata_d       = sdata_q;
    if (fall_evt) begin
      lrclk_d = slot_nxt;
      sdata_d = in_data & word_bit;
    end
    frame_start_d = frame_load;
    underrun_d    = frame_load && !hold_full_q;
  end

  // State register; reset parks the link in the last right-slot bit so the first fall starts a frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q     <= '0;
      bclk_q        <= 1'b0;
      bit_cnt_q     <= BIT_LAST;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      frame_q       <= '0;
      lrclk_q       <= 1'b1;
      sdata_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      bclk_q        <= bclk_d;
      bit_cnt_q     <= bit_cnt_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      frame_q       <= frame_d;
      lrclk_q       <= lrclk_d;
      sdata_q       <= sdata_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign s_if.sample_ready = ~hold_full_q;
  assign bclk              = bclk_q;
  assign lrclk             = lrclk_q;
  assign sdata             = sdata_q;
  assign frame_start       = frame_start_q;
  assign underrun          = underrun_q;

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Serialises stereo 16-bit signed PCM samples from the channel-strip filter chain (e.g. lowpass output) onto a standard I2S link to the codec DAC.
- Generates BCLK and LRCLK itself (bus master) from the system clock.
- Accepts one stereo pair per frame through a valid/ready handshake with a one-frame holding buffer.

Parameters:
- DATA_W, 16, sample width in bits per channel.
- SLOT_W, 32, BCLK periods per channel slot; must be >= DATA_W+1.
- CLK_DIV, 4, clk cycles per BCLK half-period; must be >= 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- left_in  input  DATA_W  left sample, two's complement.
- right_in  input  DATA_W  right sample, two's complement.
- sample_valid  input  1  left_in/right_in hold a new pair.
- sample_ready  output  1  holding buffer empty; pair accepted when valid && ready.
- bclk  output  1  I2S bit clock.
- lrclk  output  1  word select; 0 = left slot, 1 = right slot.
- sdata  output  1  serial data; changes only on BCLK falling edges.
- frame_start  output  1  one-clk pulse when a new frame is loaded.
- underrun  output  1  one-clk pulse when a frame is loaded with the holding buffer empty.

Behaviour:
- Reset values, applied immediately on reset_n low, including mid-frame:
  - bclk=0, lrclk=1, sdata=0, sample_ready=1, frame_start=0, underrun=0.
  - Holding buffer cleared; shift frame zeroed.
  - div_cnt=0, bit_cnt=2*SLOT_W-1.
- Clock divider:
  - div_cnt counts 0..CLK_DIV-1 and toggles bclk at terminal count.
  - BCLK period = 2*CLK_DIV clk cycles.
  - A "fall event" is the clk cycle in which bclk goes 1->0.
- On each fall event, bit_cnt increments modulo 2*SLOT_W.
  - Slot = bit_cnt / SLOT_W; position p = bit_cnt mod SLOT_W.
- lrclk = slot, updated on the fall event.
- sdata for position p:
  - 1 <= p <= DATA_W: bit DATA_W-p of the slot's sample (MSB first, one BCLK after the lrclk edge, standard I2S).
  - Otherwise: 0.
  - Updated on the same fall event.
- Frame load happens on the fall event where bit_cnt wraps to 0:
  - Holding full: copy the pair into the shift frame, clear holding, pulse frame_start.
  - Holding empty: load zeros (mute), pulse frame_start and underrun together.
  - Sample sdata at p=0 of the new frame is 0 (padding).
- Handshake:
  - sample_ready = !holding_full.
  - On valid && ready, capture both channels; ready drops the next cycle.
  - Ready rises the cycle after the frame load that empties holding.
  - valid without ready is ignored; the producer must hold data.
  - No capture while holding is full; the pair is never overwritten.
- Simultaneous capture and load with holding empty: the load sees empty and underruns. The captured pair waits for the next frame; there is no bypass.
- Latency: a pair accepted before a frame load has its left MSB on sdata at the fall event with bit_cnt=1 (2*CLK_DIV clks after the load).
- First frame after reset loads at the first fall event, at clk cycle 2*CLK_DIV-1 after reset release.

Optional Feature:
- Macro: I2S_TX_HOLD_LAST_EN.
- Defined: on underrun, the shift frame reloads the last successfully transferred pair instead of zeros. underrun still pulses. After reset the "last pair" is zero.
- Undefined: underrun loads zeros as described above.

Test Plan:
- Reset release, no samples, CLK_DIV=4 -> bclk period 8 clks; lrclk low for 32 BCLK, high for 32; sdata constantly 0; underrun pulses every 512 clks.
- Present left=0x7FFF, right=0x8000 before first load -> sdata left slot p1..16 = 0,1x15; right slot p1..16 = 1,0x15; all other positions 0; sample_ready high again after load.
- Stream 16-point 3 kHz sine (0, 12540, 23170, 30273, 32767, ...) on both channels, valid held when ready -> deserialised bench output matches input sequence exactly, no underrun after first frame.
- Assert valid in the exact clk of a frame-load fall event with holding empty -> underrun pulses, that frame is zero, the pair appears in the following frame.
- Pull reset_n low mid right slot -> same cycle: bclk=0, lrclk=1, sdata=0, sample_ready=1; after release, framing restarts as from power-up.
- With I2S_TX_HOLD_LAST_EN, send 0x1234/0xABCD once then stop -> every later frame repeats 0x1234/0xABCD with underrun pulsing each frame.
